axi_burst_reader: RTL

AXI_BURST_READER -- requirements
Module: axi_burst_reader

---
 rtl/axi_rb_pkg.sv | 18 +
 rtl/axi_burst_reader_if.sv | 56 +++++
 rtl/axi_rb_burst_calc.sv | 34 +++
 rtl/axi_burst_reader.sv | 105 ++++++++++
 4 files changed

// File: rtl/axi_rb_pkg.sv
// Shared types and helpers for the AXI burst reader: FSM state, INCR burst code,
// and the AxSIZE encoding derived from the data-bus width.
package axi_rb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic logic [2:0] axi_size_from_width(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_burst_reader_if.sv
// Command, AXI read (AR/R), output stream and status signals of the burst reader.
// The reader uses the master modport; the environment uses the slave modport.
interface axi_burst_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CNT_W-1:0]  cmd_beats;

  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arvalid;
  logic              s_axi_arready;

  logic [DATA_W-1:0] s_axi_rdata;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_beats,
    output cmd_ready,
    output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready,
    output out_data, out_valid,
    input  out_ready,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_beats,
    input  cmd_ready,
    input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready,
    input  out_data, out_valid,
    output out_ready,
    input  busy, done, err
  );
endinterface

// File: rtl/axi_rb_burst_calc.sv
// Combinational burst sizing: min(remaining, MAX_BURST), and with AXI_RB_4K_SPLIT_EN
// defined also capped at the beats left before the next 4 KiB boundary.
module axi_rb_burst_calc #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [CNT_W-1:0]  i_rem,
  output logic [8:0]        o_size
);
  localparam int BSH = $clog2(DATA_W / 8);

  logic [8:0] w_cap;
  assign w_cap = (i_rem >= CNT_W'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(i_rem);

`ifdef AXI_RB_4K_SPLIT_EN
  logic [12:0] w_room;
  logic [12:0] w_room_beats;
  logic        w_unused_hi;

  // Bytes up to the boundary; address is beat-aligned so the shift is exact.
  assign w_room       = 13'h1000 - {1'b0, i_addr[11:0]};
  assign w_room_beats = w_room >> BSH;
  assign o_size       = (w_room_beats < {4'd0, w_cap}) ? 9'(w_room_beats) : w_cap;
  assign w_unused_hi  = ^i_addr;
`else
  logic w_unused_addr;
  assign o_size        = w_cap;
  assign w_unused_addr = ^i_addr;
`endif

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read burst engine: splits a command into INCR bursts (one outstanding) and
// streams R beats straight to the consumer. Optional macro: AXI_RB_4K_SPLIT_EN.
module axi_burst_reader
  import axi_rb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input logic                clk,
  input logic                rst,
  axi_burst_reader_if.master bus
);
  localparam int BSH = $clog2(DATA_W / 8);

  rb_state_e         r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_rem;
  logic [8:0]        r_size;
  logic [8:0]        r_beat;
  logic              r_err;

  logic [8:0] w_size;
  logic       w_fire;
  logic       w_last_beat;
  logic       w_final;

  axi_rb_burst_calc #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST),
    .CNT_W    (CNT_W)
  ) u_calc (
    .i_addr(r_addr),
    .i_rem (r_rem),
    .o_size(w_size)
  );

  assign w_fire      = (r_state == ST_DATA) && bus.s_axi_rvalid && bus.out_ready;
  assign w_last_beat = (r_beat == r_size - 9'd1);
  assign w_final     = (r_rem == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.cmd_valid) w_next = (bus.cmd_beats == '0) ? ST_DONE : ST_ADDR;
      ST_ADDR: if (bus.s_axi_arready) w_next = ST_DATA;
      ST_DATA: if (w_fire && w_last_beat) w_next = w_final ? ST_DONE : ST_ADDR;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready     = (r_state == ST_IDLE);
    bus.s_axi_arvalid = (r_state == ST_ADDR);
    bus.s_axi_araddr  = r_addr;
    bus.s_axi_arlen   = 8'(w_size - 9'd1);
    bus.s_axi_arsize  = axi_size_from_width(DATA_W);
    bus.s_axi_arburst = AXI_BURST_INCR;
    bus.s_axi_rready  = (r_state == ST_DATA) && bus.out_ready;
    bus.out_valid     = (r_state == ST_DATA) && bus.s_axi_rvalid;
    bus.out_data      = bus.s_axi_rdata;
    bus.busy          = (r_state != ST_IDLE);
    bus.done          = (r_state == ST_DONE);
    bus.err           = r_err;
  end

  // The engine trusts its own beat count; a misplaced rlast only flags err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_size <= '0;
      r_beat <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.cmd_valid) begin
          r_addr <= bus.cmd_addr;
          r_rem  <= bus.cmd_beats;
          r_err  <= 1'b0;
        end
        ST_ADDR: if (bus.s_axi_arready) begin
          r_size <= w_size;
          r_beat <= '0;
        end
        ST_DATA: if (w_fire) begin
          r_beat <= r_beat + 9'd1;
          r_rem  <= r_rem - CNT_W'(1);
          if (bus.s_axi_rlast != w_last_beat) r_err <= 1'b1;
          if (w_last_beat && !w_final) r_addr <= r_addr + (ADDR_W'(r_size) << BSH);
        end
        default: ;
      endcase
    end
  end

endmodule
